// File: rtl/mix_ctrl_seq_if.sv
// Sensor/valve bundle for the sequenced mixing controller.
// The master side drives sensors and commands, and the slave side is the controller.
interface mix_ctrl_seq_if #(
  parameter int unsigned CW = 7
);
  logic          start;
  logic          abort;
  logic          lim;
  logic          min_lvl;
  logic          empty;
  logic [CW-1:0] conc_cur;
  logic [CW-1:0] conc_tgt;
  logic          valve_a;
  logic          valve_b;
  logic          mixer;
  logic          drain;
  logic          busy;
  logic          done;
  logic          fault;
  logic [2:0]    state;

  modport master (
    output start, abort, lim, min_lvl, empty, conc_cur, conc_tgt,
    input  valve_a, valve_b, mixer, drain, busy, done, fault, state
  );

  modport slave (
    input  start, abort, lim, min_lvl, empty, conc_cur, conc_tgt,
    output valve_a, valve_b, mixer, drain, busy, done, fault, state
  );
endinterface

// File: rtl/mix_ctrl_seq.sv
// Batch mixing controller: dose to target, mix for a fixed time, drain until empty.
// Every output is registered from the next state, so input-to-output latency is one cycle.
module mix_ctrl_seq #(
  parameter int unsigned CW         = 7,
  parameter int unsigned CMAX       = 100,
  parameter int unsigned TOL        = 0,
  parameter int unsigned MIX_CYCLES = 16,
  parameter int unsigned DRAIN_TO   = 1024
) (
  input logic           clk,
  input logic           rst,
  mix_ctrl_seq_if.slave bus
);

  localparam int unsigned CntMax = (MIX_CYCLES > DRAIN_TO) ? MIX_CYCLES : DRAIN_TO;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] MixLast   = CntW'(MIX_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_TO - 1);
  localparam logic [CW:0]     CmaxX     = (CW + 1)'(CMAX);
  localparam logic [CW:0]     TolX      = (CW + 1)'(TOL);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDose  = 3'd1,
    StMix   = 3'd2,
    StDrain = 3'd3,
    StFault = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   tgt_q, tgt_d, tgt_sat;

  logic valve_a_q, valve_a_d;
  logic valve_b_q, valve_b_d;
  logic mixer_q, mixer_d;
  logic drain_q, drain_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  // Band limits use one extra bit so tgt + TOL cannot wrap.
  logic [CW:0] tgt_x, cur_x, lo, hi;

  assign tgt_sat = ({1'b0, bus.conc_tgt} > CmaxX) ? CmaxX[CW-1:0] : bus.conc_tgt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          tgt_d   = tgt_sat;
          state_d = StDose;
        end
      end
      StDose: begin
        if (bus.abort) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else if (bus.lim) begin
          state_d = StMix;
          cnt_d   = '0;
        end
      end
      StMix: begin
        if (bus.abort || (cnt_q == MixLast)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        // Empty takes precedence over a simultaneous timeout.
        if (bus.empty) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == DrainLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tgt_x = {1'b0, tgt_d};
    cur_x = {1'b0, bus.conc_cur};
    hi    = tgt_x + TolX;
    lo    = (tgt_x >= TolX) ? (tgt_x - TolX) : '0;
  end

  always_comb begin
    valve_a_d = 1'b0;
    valve_b_d = 1'b0;
    mixer_d   = 1'b0;
    drain_d   = 1'b0;
    busy_d    = (state_d != StIdle);
    fault_d   = (state_d == StFault);
    unique case (state_d)
      StDose: begin
        mixer_d = bus.min_lvl;
        if (cur_x < lo) begin
          valve_a_d = 1'b1;
        end else if (cur_x > hi) begin
          valve_b_d = 1'b1;
        end else if (tgt_x == CmaxX) begin
          valve_a_d = 1'b1;
        end else if (tgt_x == '0) begin
          valve_b_d = 1'b1;
        end else begin
          valve_a_d = 1'b1;
          valve_b_d = 1'b1;
        end
      end
      StMix:   mixer_d = 1'b1;
      StDrain: drain_d = 1'b1;
      StFault: drain_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tgt_q     <= '0;
      valve_a_q <= 1'b0;
      valve_b_q <= 1'b0;
      mixer_q   <= 1'b0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      valve_a_q <= valve_a_d;
      valve_b_q <= valve_b_d;
      mixer_q   <= mixer_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.valve_a = valve_a_q;
  assign bus.valve_b = valve_b_q;
  assign bus.mixer   = mixer_q;
  assign bus.drain   = drain_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mix_ctrl_seq.sv
// Scoreboard bench for mix_ctrl_seq: two instances (TOL=0 and TOL=3), both with a short drain timeout.
module tb_mix_ctrl_seq;
  localparam int unsigned CW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mix_ctrl_seq_if #(.CW(CW)) ifa ();
  mix_ctrl_seq_if #(.CW(CW)) ifb ();

  mix_ctrl_seq #(
    .CW(CW), .CMAX(100), .TOL(0), .MIX_CYCLES(16), .DRAIN_TO(8)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  mix_ctrl_seq #(
    .CW(CW), .CMAX(100), .TOL(3), .MIX_CYCLES(16), .DRAIN_TO(8)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output vector: {state, valve_a, valve_b, mixer, drain, busy, done, fault}
  function automatic logic [9:0] ov(input logic [2:0] st, input logic va, input logic vb,
                                    input logic mx, input logic dr, input logic bz,
                                    input logic dn, input logic ft);
    return {st, va, vb, mx, dr, bz, dn, ft};
  endfunction

  logic [9:0] vec_a, vec_b;
  assign vec_a = {ifa.state, ifa.valve_a, ifa.valve_b, ifa.mixer, ifa.drain, ifa.busy,
                  ifa.done, ifa.fault};
  assign vec_b = {ifb.state, ifb.valve_a, ifb.valve_b, ifb.mixer, ifb.drain, ifb.busy,
                  ifb.done, ifb.fault};

  logic [10:0] exp_q[$];
  string       tag_q[$];

  always @(posedge clk) begin
    logic [10:0] e;
    string       t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, 32'(e[10] ? vec_b : vec_a), 32'(e[9:0]));
    end
    check_eq("inv_drain_valve",
             32'((ifa.drain & (ifa.valve_a | ifa.valve_b)) |
                 (ifb.drain & (ifb.valve_a | ifb.valve_b))), 32'(0));
    check_eq("inv_done_busy", 32'((ifa.done & ifa.busy) | (ifb.done & ifb.busy)), 32'(0));
  end

  task automatic drive(input bit sel, input bit st, input bit ab, input bit lm, input bit ml,
                       input bit em, input logic [CW-1:0] cur, input logic [CW-1:0] tgt);
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.lim = 1'b0; ifa.min_lvl = 1'b0; ifa.empty = 1'b0;
    ifa.conc_cur = '0; ifa.conc_tgt = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.lim = 1'b0; ifb.min_lvl = 1'b0; ifb.empty = 1'b0;
    ifb.conc_cur = '0; ifb.conc_tgt = '0;
    if (sel) begin
      ifb.start = st; ifb.abort = ab; ifb.lim = lm; ifb.min_lvl = ml; ifb.empty = em;
      ifb.conc_cur = cur; ifb.conc_tgt = tgt;
    end else begin
      ifa.start = st; ifa.abort = ab; ifa.lim = lm; ifa.min_lvl = ml; ifa.empty = em;
      ifa.conc_cur = cur; ifa.conc_tgt = tgt;
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic cyc(input bit sel, input bit st, input bit ab, input bit lm, input bit ml,
                     input bit em, input logic [CW-1:0] cur, input logic [CW-1:0] tgt,
                     input logic [9:0] e, input string tag);
    @(negedge clk);
    drive(sel, st, ab, lm, ml, em, cur, tgt);
    exp_q.push_back({sel, e});
    tag_q.push_back(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] idle_v, mix_v, drain_v, fault_v, done_v;
    idle_v  = ov(0, 0, 0, 0, 0, 0, 0, 0);
    mix_v   = ov(2, 0, 0, 1, 0, 1, 0, 0);
    drain_v = ov(3, 0, 0, 0, 1, 1, 0, 0);
    fault_v = ov(4, 0, 0, 0, 1, 1, 0, 1);
    done_v  = ov(0, 0, 0, 0, 0, 0, 1, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_eq("reset_state_a", 32'(vec_a), 32'(idle_v));
    check_eq("reset_state_b", 32'(vec_b), 32'(idle_v));
    rst = 1'b0;

    // Asynchronous reset in the middle of a dose.
    cyc(0, 1, 0, 0, 0, 0, 20, 60, ov(1, 1, 0, 0, 0, 1, 0, 0), "pre_rst_dose");
    cyc(0, 0, 0, 0, 0, 0, 20, 60, ov(1, 1, 0, 0, 0, 1, 0, 0), "pre_rst_hold");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_eq("async_rst", 32'(vec_a), 32'(idle_v));
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 20, 60, idle_v, "no_restart");

    // Full batch with TOL=0.
    cyc(0, 1, 0, 0, 0, 0, 20, 60, ov(1, 1, 0, 0, 0, 1, 0, 0), "dose_lo");
    cyc(0, 0, 0, 0, 0, 0, 80, 60, ov(1, 0, 1, 0, 0, 1, 0, 0), "dose_hi");
    cyc(0, 1, 0, 0, 1, 0, 60, 10, ov(1, 1, 1, 1, 0, 1, 0, 0), "dose_band_start_ignored");
    cyc(0, 0, 0, 1, 1, 0, 60, 60, mix_v, "mix_entry");
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 1, 60, 60, mix_v, "mix_hold");
    cyc(0, 0, 0, 0, 0, 1, 60, 60, drain_v, "drain_entry");
    cyc(0, 0, 0, 0, 0, 1, 60, 60, done_v, "done_pulse");
    cyc(0, 0, 0, 0, 0, 1, 60, 60, idle_v, "done_once");

    // Saturated target, abort beats lim, aborted batch still reports done.
    cyc(0, 1, 0, 0, 0, 0, 100, 127, ov(1, 1, 0, 0, 0, 1, 0, 0), "sat_cmax_a_only");
    cyc(0, 0, 1, 1, 0, 0, 100, 127, drain_v, "abort_over_lim");
    cyc(0, 0, 0, 0, 0, 1, 100, 127, done_v, "abort_done");

    // Zero target, then drain timeout into FAULT.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, ov(1, 0, 1, 0, 0, 1, 0, 0), "tgt_zero_b_only");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, mix_v, "mix_entry2");
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, mix_v, "mix_hold2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, drain_v, "drain_entry2");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, drain_v, "drain_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, fault_v, "fault_timeout");
    cyc(0, 1, 0, 0, 0, 1, 0, 0, fault_v, "fault_sticky");
    cyc(0, 1, 0, 0, 0, 1, 0, 0, fault_v, "fault_sticky2");

    // Tolerance band on the TOL=3 instance.
    cyc(1, 1, 0, 0, 0, 0, 47, 50, ov(1, 1, 1, 0, 0, 1, 0, 0), "tol_lo_edge");
    cyc(1, 0, 0, 0, 0, 0, 53, 50, ov(1, 1, 1, 0, 0, 1, 0, 0), "tol_hi_edge");
    cyc(1, 0, 0, 0, 0, 0, 46, 50, ov(1, 1, 0, 0, 0, 1, 0, 0), "tol_below");
    cyc(1, 0, 0, 0, 0, 0, 54, 50, ov(1, 0, 1, 0, 0, 1, 0, 0), "tol_above");
    cyc(1, 0, 1, 0, 0, 0, 54, 50, drain_v, "tol_abort");
    cyc(1, 0, 0, 0, 0, 1, 54, 50, done_v, "tol_done");

    repeat (2) @(negedge clk);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    rst = 1'b1;
    #1 check_eq("fault_cleared_by_rst", 32'(vec_a), 32'(idle_v));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
